// File: rtl/alu_pkg.sv
// alu_pkg: ALU word/shift widths and opcode constants shared by the shift path
package alu_pkg;
   localparam int WORD_W  = 32;
   localparam int SHAMT_W = $clog2(WORD_W);
   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_SLL = 4'h5,
      ALU_SRL = 4'h6,
      ALU_SRA = 4'h7
   } alu_op_e;
   localparam alu_op_e ALU_OP_SRA = ALU_SRA;
endpackage

// File: rtl/sra_unit_if.sv
// sra_unit_if: operand/result bundle between the ALU operand mux, shifter and result mux
interface sra_unit_if #(
   parameter int WIDTH   = alu_pkg::WORD_W,
   parameter int SHAMT_W = $clog2(WIDTH)
);
   logic               in_valid;
   logic [WIDTH-1:0]   A;
   logic [SHAMT_W-1:0] shiftamt;
   logic               out_valid;
   logic [WIDTH-1:0]   shiftedA;
   modport master (output in_valid, A, shiftamt, input out_valid, shiftedA);
   modport slave  (input in_valid, A, shiftamt, output out_valid, shiftedA);
endinterface

// File: rtl/sra_stage.sv
// sra_stage: one conditional right shift by DIST, vacated bits filled with the operand sign
module sra_stage #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic             en,
   input  logic             sign,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_comb q = en ? {{DIST{sign}}, d[WIDTH-1:DIST]} : d;
endmodule

// File: rtl/sra_unit.sv
// sra_unit: registered 32-bit arithmetic right shifter, log-depth barrel, one-cycle latency
module sra_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic   clock,
   input  logic   reset,
   sra_unit_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   logic [WIDTH-1:0] chain [SW+1];
   logic [WIDTH-1:0] shifted_d, shifted_q;
   logic             valid_d, valid_q;
   assign chain[0] = bus.A;
   // Widest shift first; every stage fills with the original A sign, not its own input MSB
   for (genvar g = 0; g < SW; g++) begin : g_stage
      sra_stage #(.WIDTH(WIDTH), .DIST(1 << (SW-1-g))) u_stage (
         .en   (bus.shiftamt[SW-1-g]),
         .sign (bus.A[WIDTH-1]),
         .d    (chain[g]),
         .q    (chain[g+1])
      );
   end
   always_comb begin
      valid_d   = bus.in_valid;
      shifted_d = bus.in_valid ? chain[SW] : shifted_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= 1'b0;
         shifted_q <= '0;
      end else begin
         valid_q   <= valid_d;
         shifted_q <= shifted_d;
      end
   end
   assign bus.out_valid = valid_q;
   assign bus.shiftedA  = shifted_q;
endmodule

// File: tb/tb_sra_unit.sv
// tb_sra_unit: table vectors, hand sequences and a random stream checked through a scoreboard
module tb_sra_unit;
   import alu_pkg::*;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;
   sra_unit_if #(.WIDTH(WORD_W), .SHAMT_W(SHAMT_W)) bus ();
   sra_unit dut (.clock(clock), .reset(reset), .bus(bus));
   typedef struct {
      logic        v;
      logic [31:0] d;
      string       name;
   } exp_t;
   typedef struct {
      logic [31:0] a;
      logic [4:0]  s;
      logic [31:0] exp;
      string       name;
   } vec_t;
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last = '0;
   task automatic step(input logic r, input logic v, input logic [31:0] a,
                       input logic [4:0] s, input string name);
      exp_t        e;
      logic [31:0] m;
      @(negedge clock);
      reset        = r;
      bus.in_valid = v;
      bus.A        = a;
      bus.shiftamt = s;
      m = $signed(a) >>> s;
      if (r) last = '0;
      else if (v) last = m;
      e.v = v && !r;
      e.d = last;
      e.name = name;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== e.v) begin
         errors++;
         $display("FAIL %s out_valid: got %b want %b", e.name, bus.out_valid, e.v);
      end
      checks++;
      if (bus.shiftedA !== e.d) begin
         errors++;
         $display("FAIL %s shiftedA: got %h want %h", e.name, bus.shiftedA, e.d);
      end
   endtask
   task automatic check_const(input logic [31:0] want, input string name);
      checks++;
      if (bus.shiftedA !== want) begin
         errors++;
         $display("FAIL %s const: got %h want %h", name, bus.shiftedA, want);
      end
   endtask
   initial begin
      vec_t vecs[7];
      vecs[0] = '{32'h80000000, 5'd4,  32'hF8000000, "neg_s4"};
      vecs[1] = '{32'h80000000, 5'd31, 32'hFFFFFFFF, "neg_s31"};
      vecs[2] = '{32'h80000000, 5'd0,  32'h80000000, "neg_s0"};
      vecs[3] = '{32'h7FFFFFFF, 5'd31, 32'h00000000, "pos_s31"};
      vecs[4] = '{32'h7FFFFFFF, 5'd1,  32'h3FFFFFFF, "pos_s1"};
      vecs[5] = '{32'h38797400, 5'd1,  32'h1C3CBA00, "sweep_s1"};
      vecs[6] = '{32'hF0000000, 5'd8,  32'hFFF00000, "pulse_s8"};
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.shiftamt = '0;
      step(1'b1, 1'b1, 32'hFFFFFFFF, 5'd0, "reset0");
      step(1'b1, 1'b1, 32'hFFFFFFFF, 5'd31, "reset1");
      for (int n = 1; n <= 15; n++) step(1'b0, 1'b1, 32'h38797400, 5'(n), "pos_sweep");
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, vecs[i].a, vecs[i].s, vecs[i].name);
         check_const(vecs[i].exp, vecs[i].name);
      end
      step(1'b0, 1'b0, 32'h12345678, 5'd3, "idle_a");
      step(1'b0, 1'b1, 32'hF0000000, 5'd8, "pulse");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, $urandom, 5'($urandom_range(31)), "hold");
         check_const(32'hFFF00000, "hold_val");
      end
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) step(1'b1, 1'b1, $urandom, 5'($urandom_range(31)), "mid_reset");
         else step(1'b0, ($urandom_range(3) != 0), $urandom, 5'($urandom_range(31)), "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
